// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and helpers for multi_channel_serializer.
//   state_t   - frame FSM states (IDLE, SHIFT)
//   len_bits  - width of the length field able to hold 0..width
//   eff_len   - effective frame length: 0 or over-range maps to width
package serializer_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  function automatic int len_bits(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int eff_len(input int len, input int width);
    return (len == 0 || len > width) ? width : len;
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// serializer_lane: one WIDTH-bit parallel-to-serial shift register.
//   clk, rst        clock, async active-high reset
//   load            capture data/len/msb_first (wins over shift)
//   shift           advance one bit
//   msb_first, len  order and effective length of the word being loaded
//   data            parallel word
//   bit_out         bit currently at the output end of the register
module serializer_lane import serializer_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int LEN_W = len_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             msb_first,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] data,
  output logic             bit_out
);

  logic [WIDTH-1:0] sreg;
  logic             dir;
  logic [LEN_W-1:0] pad;

  // MSB-first words shorter than WIDTH are pre-aligned so bit len-1 sits at
  // the top; the shift path is then identical for every length.
  assign pad = LEN_W'(WIDTH) - len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      dir  <= 1'b0;
    end else if (load) begin
      sreg <= msb_first ? (data << pad) : data;
      dir  <= msb_first;
    end else if (shift) begin
      sreg <= dir ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    end
  end

  assign bit_out = dir ? sreg[WIDTH-1] : sreg[0];

endmodule

// File: rtl/multi_channel_serializer.sv
// multi_channel_serializer: captures CHANNELS words of WIDTH bits in one
// valid/ready handshake and shifts them out bit-serially in lockstep.
//   clk_i, reset_i              clock, async active-high reset
//   load_valid_i/load_ready_o   word-set handshake
//   data_i                      lane c at [c*WIDTH +: WIDTH]
//   len_i, msb_first_i          frame length (0/over-range = WIDTH), order
//   enable_i                    shift advance, low stalls
//   serial_o, serial_valid_o    per-lane bit and freshness flag
//   first_o, last_o, done_o     framing
//   busy_o                      frame in progress
// Optional macro SERIALIZER_PRELOAD_EN adds a one-entry holding register so
// the next word set can be accepted mid-frame for gapless streams.
module multi_channel_serializer import serializer_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int LEN_W    = len_bits(WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0]          len_i,
  input  logic                      msb_first_i,
  input  logic                      enable_i,
  output logic [CHANNELS-1:0]       serial_o,
  output logic                      serial_valid_o,
  output logic                      first_o,
  output logic                      last_o,
  output logic                      done_o,
  output logic                      busy_o
);

  state_t                    state, state_nxt;
  logic [LEN_W-1:0]          cnt, len_r, len_in;
  logic                      accept, emit, is_last;
  logic                      take_in, take_hold, lane_load;
  logic [CHANNELS*WIDTH-1:0] ld_data;
  logic [LEN_W-1:0]          ld_len;
  logic                      ld_msb;
  logic [CHANNELS-1:0]       lane_bits;

  assign len_in  = LEN_W'(eff_len(int'(len_i), WIDTH));
  assign accept  = load_valid_i && load_ready_o;
  assign emit    = (state == SHIFT) && enable_i;
  assign is_last = (cnt == len_r - LEN_W'(1));
  // A new word goes straight into the lanes when idle, or when it arrives on
  // the very edge the current frame finishes (hold is empty then).
  assign take_in   = accept && ((state == IDLE) || (emit && is_last));
  assign lane_load = take_in || take_hold;

`ifdef SERIALIZER_PRELOAD_EN
  logic                      hold_full;
  logic [CHANNELS*WIDTH-1:0] hold_data;
  logic [LEN_W-1:0]          hold_len;
  logic                      hold_msb;

  assign take_hold    = emit && is_last && hold_full;
  assign load_ready_o = !hold_full;
  assign ld_data      = take_hold ? hold_data : data_i;
  assign ld_len       = take_hold ? hold_len  : len_in;
  assign ld_msb       = take_hold ? hold_msb  : msb_first_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_len  <= '0;
      hold_msb  <= 1'b0;
    end else if (accept && !take_in) begin
      hold_full <= 1'b1;
      hold_data <= data_i;
      hold_len  <= len_in;
      hold_msb  <= msb_first_i;
    end else if (take_hold) begin
      hold_full <= 1'b0;
    end
  end
`else
  assign take_hold    = 1'b0;
  assign load_ready_o = (state == IDLE);
  assign ld_data      = data_i;
  assign ld_len       = len_in;
  assign ld_msb       = msb_first_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (emit && is_last && !lane_load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt   <= '0;
      len_r <= '0;
    end else if (lane_load) begin
      cnt   <= '0;
      len_r <= ld_len;
    end else if (emit) begin
      cnt   <= cnt + 1'b1;
    end
  end

  // Stall in SHIFT keeps serial/first/last; idle clears the framing flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      serial_o       <= '0;
      serial_valid_o <= 1'b0;
      first_o        <= 1'b0;
      last_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      serial_valid_o <= emit;
      done_o         <= emit && is_last;
      if (emit) begin
        serial_o <= lane_bits;
        first_o  <= (cnt == '0);
        last_o   <= is_last;
      end else if (state == IDLE) begin
        first_o  <= 1'b0;
        last_o   <= 1'b0;
      end
    end
  end

  assign busy_o = (state == SHIFT);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serializer_lane #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_lane (
      .clk       (clk_i),
      .rst       (reset_i),
      .load      (lane_load),
      .shift     (emit),
      .msb_first (ld_msb),
      .len       (ld_len),
      .data      (ld_data[c*WIDTH +: WIDTH]),
      .bit_out   (lane_bits[c])
    );
  end

endmodule

// File: doc/multi_channel_serializer.md
# multi_channel_serializer

Parametrised parallel-to-serial shifter feeding the serial adder datapath: captures CHANNELS operand words of WIDTH bits in one handshake and shifts them out bit-serially, all lanes in lockstep. Successor to the two-operand fixed-width shifter, adding:
- channel count and width generics;
- a valid/ready load handshake;
- a per-word length and LSB/MSB-first order;
- framing outputs (first/last/done);
- an optional preload buffer for gapless streams.

## Interface
- WIDTH, 8, bits per channel word (≥2)
- CHANNELS, 2, number of lanes shifted in parallel (≥1)
- LEN_W, $clog2(WIDTH+1), width of len_i
- clk_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- load_valid_i  in  1  parallel word set offered
- load_ready_o  out  1  block can accept a word set
- data_i  in  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH]
- len_i  in  LEN_W  bits to emit; 0 or >WIDTH means WIDTH
- msb_first_i  in  1  1: emit bit len-1 down to 0; 0: emit bit 0 up to len-1
- enable_i  in  1  shift advance; low stalls
- serial_o  out  CHANNELS  current serial bit per lane
- serial_valid_o  out  1  serial_o carries a fresh bit this cycle
- first_o  out  1  current bit is bit 0 of the frame
- last_o  out  1  current bit is the final bit of the frame
- done_o  out  1  one-cycle pulse, coincident with last_o
- busy_o  out  1  a frame is in progress

## Operation
- FSM states: IDLE, SHIFT.
- Load acceptance: a word set is accepted on a rising edge with load_valid_i && load_ready_o. On acceptance, data_i, the effective length and msb_first_i are captured.
- IDLE → SHIFT on acceptance.
- SHIFT: each edge with enable_i=1 emits one bit per lane to serial_o and increments the bit counter.
- End of frame: the edge emitting bit number len-1 sets last_o=1 and done_o=1 and returns to IDLE, unless a preloaded word is pending (see Configuration).
- enable_i=0 in SHIFT: serial_o, first_o and last_o hold; serial_valid_o=0 and done_o=0 next cycle; the counter holds.
- enable_i has no effect in IDLE.
- busy_o = (state==SHIFT).
- Lanes never diverge: one shared counter and length for all lanes.
- Reset at any point, including mid-frame: state IDLE, any preload discarded, and outputs forced to reset values immediately.
- Reset values: serial_o=0, serial_valid_o=0, first_o=0, last_o=0, done_o=0, busy_o=0, load_ready_o=1.

## Timing
- All outputs are registered or derived only from registers; there is no combinational path from inputs to outputs.
- Load latency: acceptance at edge k; with enable_i held high, the first bit is visible after edge k+1 with first_o=1.
- A len=L frame occupies L consecutive serial_valid_o cycles.
- Without preload: load_ready_o = (state==IDLE). One bubble cycle separates back-to-back frames:
  - last bit at edge n;
  - next word accepted at edge n+1;
  - its first bit at edge n+2.
- len=1: first_o, last_o and done_o all assert in the same cycle.

## Configuration
- SERIALIZER_PRELOAD_EN defined:
  - adds a one-entry holding register (data, len, order) and load_ready_o = !hold_full;
  - a word set may be accepted during SHIFT;
  - on the edge emitting the last bit with the hold full, the holding contents move into the shift registers, state stays SHIFT and the hold empties;
  - the next edge with enable_i=1 emits the new frame's first bit, so there is zero bubble between frames;
  - a load and a transfer on the same edge are impossible because ready is low while the hold is full.
- Undefined: no holding register, behaviour as in Timing. Reset clears the hold.

## Structure
- Package serializer_pkg:
  - state enum (IDLE, SHIFT);
  - an effective-length function (0/over-range → WIDTH);
  - the LEN_W computation.
- Sub-module serializer_lane: one WIDTH-bit shift register with load, shift, direction and output bit, instantiated CHANNELS times.
- Top level owns the FSM, counter, holding register and framing outputs.

## Test plan
- Reset release; load WIDTH=8, CHANNELS=2, lane0=8'hA5, lane1=8'h3C, len=0, LSB-first, enable high:
  - lane0 serial 1,0,1,0,0,1,0,1 and lane1 0,0,1,1,1,1,0,0;
  - first_o on bit 0; last_o/done_o on bit 7;
  - then IDLE, load_ready_o=1.
- Same data, msb_first_i=1, len=4:
  - lane0 emits 0,1,0,1 (bits 3..0);
  - done_o after the 4th bit.
- enable_i low for 3 cycles after bit 2:
  - serial_o holds;
  - serial_valid_o=0 for 3 cycles;
  - remaining bits resume unchanged and the frame totals 8 valid cycles.
- reset_i pulsed asynchronously mid-frame (after bit 3):
  - all outputs 0 immediately, load_ready_o=1 after release;
  - no residual bits emitted.
- Back-to-back frames with load_valid_i held high:
  - without SERIALIZER_PRELOAD_EN, exactly one serial_valid_o=0 cycle between frames;
  - with it, 16 contiguous valid cycles and done_o pulsing twice.
- len=1 with lane0=8'h01: a single valid cycle with serial_o[0]=1 and first_o=last_o=done_o=1.
